// File: rtl/switch_responder_pkg.sv
// switch_responder_pkg: IO map constants shared by the LED and switch responders
package switch_responder_pkg;
  localparam int SW_WIDTH = 16;
  localparam logic [31:0] LED_BASE = 32'hFFFFFC60;
  localparam logic [31:0] SWITCH_BASE = 32'hFFFFFC70;
  localparam logic [1:0] SW_OFS_VAL = 2'b00;
  localparam logic [1:0] SW_OFS_FLAG = 2'b10;
  typedef logic [SW_WIDTH-1:0] sw_word_t;
endpackage

// File: rtl/switch_responder_debounce_bit.sv
// debounce_bit: two-flop synchroniser, stability counter and debounced flop for one switch
module debounce_bit #(
  parameter int DB_CYCLES = 20000,
  parameter int CNT_W = 15,
  parameter logic RST_BIT = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic pin_i,
  output logic deb_o,
  output logic chg_o
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DB_CYCLES - 1);
  logic s1_q, s2_q, deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign chg_o = (s2_q != deb_q) && (cnt_q == LAST);
  assign deb_o = deb_q;
  always_comb begin
    cnt_d = (s2_q == deb_q || chg_o) ? '0 : cnt_q + 1'b1;
    deb_d = chg_o ? s2_q : deb_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q <= RST_BIT;
      s2_q <= RST_BIT;
      deb_q <= RST_BIT;
      cnt_q <= '0;
    end else begin
      s1_q <= pin_i;
      s2_q <= s1_q;
      deb_q <= deb_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/switch_responder.sv
// switch_responder: debounced switch bank with sticky read-to-clear change flags
module switch_responder
  import switch_responder_pkg::*;
#(
  parameter int DB_CYCLES = 20000,
  parameter int CNT_W = 15,
  parameter logic [15:0] RST_VAL = 16'h0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        switchcs,
  input  logic [1:0]  switaddr,
  input  logic        switread,
  input  logic [15:0] switch_i,
  output logic [15:0] switchrdata
);
  sw_word_t deb, chg, flag_q, flag_d;
  logic rd, clr;
  for (genvar i = 0; i < SW_WIDTH; i++) begin : g_bit
    debounce_bit #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W), .RST_BIT(RST_VAL[i])) u_bit (
      .clock(clock),
      .reset(reset),
      .pin_i(switch_i[i]),
      .deb_o(deb[i]),
      .chg_o(chg[i])
    );
  end
  // a change landing on the clearing edge survives the clear
  always_comb begin
    rd = switchcs && switread;
    clr = rd && switaddr == SW_OFS_FLAG;
    flag_d = (clr ? '0 : flag_q) | chg;
    switchrdata = !rd ? '0 : switaddr == SW_OFS_VAL ? deb : switaddr == SW_OFS_FLAG ? flag_q : '0;
  end
  always_ff @(posedge clock) begin
    if (reset) flag_q <= '0;
    else flag_q <= flag_d;
  end
endmodule

// File: tb/tb_switch_responder.sv
// tb_switch_responder: directed plan plus random traffic against a sample-history reference model
module tb_switch_responder;
  localparam int DB = 4;
  logic clock = 1'b0, reset, switchcs, switread;
  logic [1:0] switaddr;
  logic [15:0] switch_i, switchrdata;
  int n_cmp = 0, n_bad = 0;
  logic [15:0] s1_m = '0, s2_m = '0, deb_m = '0, flag_m = '0, obs;
  logic [15:0] hist[$];
  logic [15:0] pin;

  always #5 clock = ~clock;

  switch_responder #(.DB_CYCLES(DB), .CNT_W(3), .RST_VAL(16'h0000)) dut (
    .clock(clock),
    .reset(reset),
    .switchcs(switchcs),
    .switaddr(switaddr),
    .switread(switread),
    .switch_i(switch_i),
    .switchrdata(switchrdata)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model_rd();
    if (!(switchcs && switread)) return 16'h0000;
    return switaddr == 2'b00 ? deb_m : switaddr == 2'b10 ? flag_m : 16'h0000;
  endfunction

  // debounced bit flips once the last DB synchronised samples all disagree with it
  task automatic cyc(input logic rst, input logic cs, input logic rd, input logic [1:0] a, input logic [15:0] p);
    logic [15:0] chg;
    bit all;
    reset = rst; switchcs = cs; switread = rd; switaddr = a; switch_i = p;
    #1;
    obs = switchrdata;
    check("rdata", obs, model_rd());
    if (rst) begin
      s1_m = '0; s2_m = '0; deb_m = '0; flag_m = '0;
      hist.delete();
    end else begin
      hist.push_back(s2_m);
      if (hist.size() > DB) void'(hist.pop_front());
      chg = '0;
      for (int b = 0; b < 16; b++) begin
        if (hist.size() == DB) begin
          all = 1;
          foreach (hist[k]) if (hist[k][b] == deb_m[b]) all = 0;
          chg[b] = all;
        end
      end
      if (cs && rd && a == 2'b10) flag_m = '0;
      flag_m |= chg;
      deb_m ^= chg;
      s2_m = s1_m;
      s1_m = p;
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    cyc(1, 0, 0, 2'b00, 16'hFFFF);
    cyc(1, 0, 0, 2'b00, 16'hFFFF);
    for (int k = 1; k <= 8; k++) begin
      cyc(0, 1, 1, 2'b00, 16'hFFFF);
      check("p1_val", obs, k >= 7 ? 16'hFFFF : 16'h0000);
    end
    cyc(0, 1, 1, 2'b10, 16'hFFFF);
    check("p1_flag", obs, 16'hFFFF);
    cyc(0, 1, 1, 2'b10, 16'hFFFF);
    check("p1_clr", obs, 16'h0000);
    for (int k = 0; k < 8; k++) cyc(0, 0, 0, 2'b00, 16'h0000);
    cyc(0, 1, 1, 2'b10, 16'h0000);
    check("p1_fall", obs, 16'hFFFF);
    for (int k = 0; k < 9; k++) begin
      cyc(0, 1, 1, 2'b00, k < 3 ? 16'h0008 : 16'h0000);
      check("p2_glitch", obs, 16'h0000);
    end
    cyc(0, 1, 1, 2'b10, 16'h0000);
    check("p2_flag", obs, 16'h0000);
    for (int k = 1; k <= 8; k++) begin
      cyc(0, 1, 1, 2'b00, 16'h0008);
      check("p2_val", obs, k >= 7 ? 16'h0008 : 16'h0000);
    end
    cyc(0, 1, 1, 2'b10, 16'h0008);
    check("p3_flag", obs, 16'h0008);
    cyc(0, 1, 1, 2'b10, 16'h0008);
    check("p3_clr", obs, 16'h0000);
    for (int k = 1; k <= 5; k++) cyc(0, 1, 1, 2'b00, 16'h0028);
    cyc(0, 1, 1, 2'b10, 16'h0028);
    check("p4_old", obs, 16'h0000);
    cyc(0, 1, 1, 2'b10, 16'h0028);
    check("p4_keep", obs, 16'h0020);
    for (int k = 0; k < 8; k++) cyc(0, 0, 0, 2'b00, 16'hA5A5);
    cyc(0, 0, 1, 2'b00, 16'hA5A5);
    check("p5_nocs", obs, 16'h0000);
    cyc(0, 1, 0, 2'b10, 16'hA5A5);
    check("p5_write", obs, 16'h0000);
    cyc(0, 1, 1, 2'b01, 16'hA5A5);
    check("p5_rsv", obs, 16'h0000);
    cyc(0, 1, 1, 2'b00, 16'hA5A5);
    check("p5_val", obs, 16'hA5A5);
    cyc(0, 1, 1, 2'b10, 16'hA5A5);
    check("p5_flag", obs, 16'hA58D);
    for (int k = 0; k < 4; k++) cyc(0, 0, 0, 2'b00, 16'hA525);
    cyc(1, 0, 0, 2'b00, 16'hA525);
    for (int k = 1; k <= 7; k++) begin
      cyc(0, 1, 1, 2'b00, 16'hA525);
      check("p6_val", obs, k >= 7 ? 16'hA525 : 16'h0000);
    end
    cyc(0, 1, 1, 2'b10, 16'hA525);
    check("p6_flag", obs, 16'hA525);
    pin = 16'hA525;
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 3) == 0) pin[$urandom_range(0, 15)] ^= 1'b1;
      cyc($urandom_range(0, 99) == 0, 1'($urandom), 1'($urandom), 2'($urandom), pin);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/switch_responder.md
Name: switch_responder

Overview:
- IO-side responder to the CPU's switch chip select. The memory/IO decoder raises the select on an IO access to 0xFFFFFC70 and forwards the 16-bit read data into the low half of the register-file write-back (upper 16 bits zero-filled there).
- Captures the 16 board switches, synchronises and per-bit debounces them, and keeps sticky change flags.
- Drives the 16-bit IO read bus on a selected read.

Parameters:
DB_CYCLES, 20000, consecutive stable cycles required before a debounced bit flips (min 1)
CNT_W, 15, debounce counter width; must satisfy 2^CNT_W > DB_CYCLES
RST_VAL, 16'h0000, debounced value loaded at reset

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
switchcs  input  1  chip select from the IO decoder (SwitchCtrl)
switaddr  input  2  caddress[1:0]; 2'b00 = debounced value, 2'b10 = change flags, others reserved
switread  input  1  IO read strobe (ioread)
switch_i  input  16  raw asynchronous switch pins
switchrdata  output  16  read data to the decoder's ioread_data

Behaviour:
- One clock domain (clock). Reset is synchronous and active-high, sampled on the rising edge.
- Reset values:
  - sync stages = RST_VAL
  - debounced reg = RST_VAL
  - all counters = 0
  - change flags = 16'h0000
  - switchrdata = 0 (combinational from reset state)
- Synchroniser: two flops per bit, switch_i -> s1 -> s2.
  - s2 is the only consumer of pin data.
- Per-bit debounce, bit i:
  - s2[i] == deb[i]: cnt[i] <= 0.
  - s2[i] != deb[i] and cnt[i] < DB_CYCLES-1: cnt[i] <= cnt[i]+1.
  - s2[i] != deb[i] and cnt[i] == DB_CYCLES-1: deb[i] <= s2[i], cnt[i] <= 0, flag[i] <= 1.
  - A glitch shorter than DB_CYCLES cycles at s2 never reaches deb.
  - Any return to equality restarts the count from 0.
  - Pin-to-deb latency = 2 + DB_CYCLES rising edges.
  - Counter never exceeds DB_CYCLES-1, so no wrap-around.
- Read path (combinational, same cycle, to suit the single-cycle datapath):
  - rd = switchcs && switread.
  - rd and switaddr == 2'b00: switchrdata = deb.
  - rd and switaddr == 2'b10: switchrdata = flag.
  - rd with a reserved offset: 16'h0000.
  - !rd: 16'h0000. The decoder mux depends on the bus idling at 0.
- Flag clear (read-to-clear):
  - At the rising edge ending a cycle with rd and switaddr == 2'b10: flag <= (set_this_cycle).
  - Simultaneous set and clear on the same bit leaves the bit SET, so no event is lost.
  - Reads at offset 00 never modify state.
- Writes: switchcs without switread is a write to read-only space. It is ignored with no state change.
- Reset mid-debounce: counters and flags clear. deb returns to RST_VAL. Counting restarts from the next s2 sample.
- No handshake or wait states; every selected read completes in its cycle.

Decomposition:
- Shared IO package holds:
  - IO base addresses (LED 32'hFFFFFC60, SWITCH 32'hFFFFFC70)
  - switch register offsets (SW_OFS_VAL = 2'b00, SW_OFS_FLAG = 2'b10)
  - SW_WIDTH = 16
- Sub-module debounce_bit: one synchroniser + counter + deb flop + change pulse, parameterised by DB_CYCLES/CNT_W.
  - Instantiated 16x via generate.
  - The top level holds the flags and the read mux.

Test Plan (DB_CYCLES = 4, CNT_W = 3):
1. Reset with switch_i = 16'hFFFF, then release; read offset 00 at cycle 1 -> 16'h0000; read at edge 6 after release -> 16'hFFFF; read offset 10 -> 16'hFFFF.
2. switch_i bit 3 high for 3 cycles then low -> deb stays 16'h0000 and flag stays 16'h0000 throughout. Then hold high for 4 cycles -> deb = 16'h0008 exactly at edge 6 after the pin change.
3. Flags = 16'h0008, read offset 10 -> returns 16'h0008; next read offset 10 -> 16'h0000.
4. Bit 5 debounce completes on the same edge as a flag-clearing read -> that read returns the old flags; next read -> 16'h0020 (bit retained).
5. switchcs = 0 with switread = 1, deb = 16'hA5A5 -> switchrdata = 16'h0000. switchcs = 1, switread = 0 -> 16'h0000, no flag clear. switaddr = 2'b01 read -> 16'h0000.
6. Assert reset for one cycle while bit 7 count = 2 -> after reset, 3 further stable cycles do not flip deb; flip occurs only after 4 full cycles from the post-reset s2 mismatch.
